rf_event_arbiter: RTL and testbench
===================================

Name: rf_event_arbiter

Overview:
- Shares the register file's single write port between CPU writeback and four hardware game-event sources: piece stop, line clear, shape change and restart.
- CPU writeback has fixed priority. Event writes are queued as sticky pending bits and served round-robin in idle write cycles.
- Owns the random-shape LFSR, the score counter and the rotation counter, so the regfile no longer modifies registers behind the CPU's back.
- Sits between the processor writeback stage and the regfile write port.

Parameters:
SHAPE_REG, 1, regfile index receiving the new shape on stop
ROT_REG, 2, regfile index receiving the rotation index on change
SCORE_REG, 13, regfile index receiving the score
MAX_WAIT, 8, starvation threshold in cycles (optional feature only)

Ports:
clock  in  1  system clock, rising edge
ctrl_reset  in  1  asynchronous active-high reset
cpu_we  in  1  CPU writeback enable
cpu_waddr  in  5  CPU writeback register index
cpu_wdata  in  32  CPU writeback data
ev_stop  in  1  level; piece landed
ev_clear  in  1  level; line cleared
ev_change  in  1  level; rotate request
start_over  in  1  active-low game restart, synchronous
rf_we  out  1  regfile write enable
rf_waddr  out  5  regfile write index
rf_wdata  out  32  regfile write data
cpu_stall  out  1  CPU must hold writeback (optional feature, else 0)
shape  out  4  current shape, 0..14
score  out  32  current score
pending  out  4  {restart, change, clear, stop} pending bits

Behaviour:
Reset:
- All state clears: edge registers, pending bits, clear count, score, rotation, shape, round-robin pointer (pointer set to stop).
- LFSR loads 16'hACE1.
- All outputs 0.

Event capture:
- Each event input and start_over is registered. A rising edge (now 1, previous 0) sets its pending bit at that clock edge.
- A restart edge is a start_over 0->1 transition.
- stop, change and restart coalesce: an edge while already pending is absorbed.
- clear keeps a 4-bit pending count that saturates at 15. Its pending bit = count != 0.

LFSR:
- 16-bit Galois, mask 16'hB400, advances every clock.
- Candidate shape = lfsr[3:0], mapped to 0 when it equals 15.

Write mux (combinational outputs):
- If cpu_we and cpu_waddr != 0: rf_* = CPU values. No event is granted that cycle.
- Else if any bit is pending: grant the first pending source at or after the pointer, in order stop -> clear -> change -> restart -> stop. On the next edge, the pointer moves to the source after the granted one.
- Else rf_we = 0, rf_waddr = 0, rf_wdata = 0.

Grant actions (all take effect at the clock edge ending the grant cycle):
- stop: write {28'b0, candidate} to SHAPE_REG. shape <= candidate. Rotation <= 0. Clear pending.
- clear: write score+1 to SCORE_REG. score <= score+1 (wraps at 2^32). Decrement count.
- change: write {30'b0, rot+1} to ROT_REG. Rotation is a 2-bit counter and wraps 3->0. Clear pending.
- restart: write 0 to SCORE_REG. Clear pending.

Latency and simultaneous events:
- Event edge sampled at edge k: rf_we is high in the cycle after edge k at the earliest, and the regfile commits at edge k+1.
- An event edge arriving in the same cycle its own grant retires re-sets pending for stop/change/restart. For clear, the count does net +1-1 = unchanged.

start_over low:
- Every cycle: pending bits and clear count forced to 0, new edges ignored, score and rotation held at 0.
- CPU writes still pass through.

CPU write to SCORE_REG:
- Also loads the internal score from cpu_wdata, keeping score and regfile coherent.
- A CPU write to SHAPE_REG does not alter shape.

Optional Feature:
EVT_STARVE_GUARD_EN:
- Enabled: a 4-bit wait counter increments each cycle in which a pending exists but a CPU write wins. The counter clears on any grant or when nothing is pending.
- When the counter reaches MAX_WAIT: cpu_stall = 1 for one cycle, the event is granted in place of the CPU write, and the CPU must hold cpu_we/cpu_waddr/cpu_wdata for that cycle.
- Disabled: cpu_stall is constant 0 and CPU always wins.

Test Plan:
1. Reset, then a single ev_stop pulse with no CPU writes -> one cycle later rf_we=1, rf_waddr=1, rf_wdata = mapped LFSR nibble; shape matches; pending=0.
2. Three ev_clear pulses then idle -> three consecutive writes to r13 with data 1, 2, 3; score=3.
3. stop, clear and change edges in the same cycle -> grants in order r1, r13, r2 on consecutive cycles; rf_wdata for r2 = 1.
4. CPU writes r5=32'h1234 every cycle while ev_change pulses -> no event write while CPU is busy; r2 write in the first CPU-idle cycle. With EVT_STARVE_GUARD_EN: cpu_stall=1 at wait count 8, and the event is granted that cycle.
5. score=7, start_over low 2 cycles during a clear edge, then high -> clear ignored; restart grant writes r13=0; score=0.
6. ctrl_reset asserted mid-grant with rf_we=1 -> outputs 0 immediately (asynchronous); pending=0 after release; LFSR restarts from 16'hACE1.

Source files
------------

// File: rtl/rf_event_arbiter.sv
// Regfile write-port arbiter: CPU writeback has priority, game events are served round-robin in idle cycles.
// Define EVT_STARVE_GUARD_EN to let an event starved for MAX_WAIT cycles stall the CPU for one cycle.
module rf_event_arbiter #(
  parameter logic [4:0] SHAPE_REG = 5'd1,
  parameter logic [4:0] ROT_REG   = 5'd2,
  parameter logic [4:0] SCORE_REG = 5'd13
`ifdef EVT_STARVE_GUARD_EN
  ,
  parameter logic [3:0] MAX_WAIT  = 4'd8
`endif
) (
  input  logic        clock,
  input  logic        ctrl_reset,
  input  logic        cpu_we,
  input  logic [4:0]  cpu_waddr,
  input  logic [31:0] cpu_wdata,
  input  logic        ev_stop,
  input  logic        ev_clear,
  input  logic        ev_change,
  input  logic        start_over,
  output logic        rf_we,
  output logic [4:0]  rf_waddr,
  output logic [31:0] rf_wdata,
  output logic        cpu_stall,
  output logic [3:0]  shape,
  output logic [31:0] score,
  output logic [3:0]  pending
);

  localparam logic [1:0] SRC_STOP    = 2'd0;
  localparam logic [1:0] SRC_CLEAR   = 2'd1;
  localparam logic [1:0] SRC_CHANGE  = 2'd2;
  localparam logic [1:0] SRC_RESTART = 2'd3;

  logic        stop_prev_q, clear_prev_q, change_prev_q, so_prev_q;
  logic        stop_pend_q, stop_pend_d;
  logic        change_pend_q, change_pend_d;
  logic        restart_pend_q, restart_pend_d;
  logic [3:0]  clear_cnt_q, clear_cnt_d;
  logic [31:0] score_q, score_d;
  logic [1:0]  rot_q, rot_d;
  logic [3:0]  shape_q, shape_d;
  logic [1:0]  ptr_q, ptr_d;
  logic [15:0] lfsr_q, lfsr_d;

  logic        stop_edge, clear_edge, change_edge, restart_edge;
  logic [3:0]  pend_vec;
  logic        any_pend, cpu_win, force_evt, grant_valid;
  logic [1:0]  grant_src;
  logic [3:0]  cand;

  assign stop_edge    = ev_stop & ~stop_prev_q;
  assign clear_edge   = ev_clear & ~clear_prev_q;
  assign change_edge  = ev_change & ~change_prev_q;
  assign restart_edge = start_over & ~so_prev_q;

  assign pend_vec    = {restart_pend_q, change_pend_q, (clear_cnt_q != 4'd0), stop_pend_q};
  assign any_pend    = start_over & (|pend_vec);
  assign cpu_win     = cpu_we & (cpu_waddr != 5'd0);
  assign grant_valid = any_pend & (~cpu_win | force_evt);
  assign cand        = (lfsr_q[3:0] == 4'hF) ? 4'h0 : lfsr_q[3:0];

`ifdef EVT_STARVE_GUARD_EN
  logic [3:0] wait_q, wait_d;

  assign force_evt = cpu_win & any_pend & (wait_q == MAX_WAIT);

  always_comb begin
    wait_d = wait_q;
    if (!any_pend || grant_valid) wait_d = 4'd0;
    else if (cpu_win)             wait_d = wait_q + 4'd1;
  end

  always_ff @(posedge clock or posedge ctrl_reset) begin
    if (ctrl_reset) wait_q <= 4'd0;
    else            wait_q <= wait_d;
  end
`else
  assign force_evt = 1'b0;
`endif

  assign cpu_stall = force_evt & ~ctrl_reset;

  // Scanning from the farthest offset down leaves the nearest pending source after the pointer.
  always_comb begin
    grant_src = ptr_q;
    for (int i = 3; i >= 0; i--) begin
      if (pend_vec[ptr_q + 2'(i)]) grant_src = ptr_q + 2'(i);
    end
  end

  always_comb begin
    rf_we    = 1'b0;
    rf_waddr = 5'd0;
    rf_wdata = 32'd0;
    if (ctrl_reset) begin
      rf_we = 1'b0;
    end else if (cpu_win && !force_evt) begin
      rf_we    = 1'b1;
      rf_waddr = cpu_waddr;
      rf_wdata = cpu_wdata;
    end else if (grant_valid) begin
      rf_we = 1'b1;
      case (grant_src)
        SRC_STOP:   begin rf_waddr = SHAPE_REG; rf_wdata = {28'd0, cand}; end
        SRC_CLEAR:  begin rf_waddr = SCORE_REG; rf_wdata = score_q + 32'd1; end
        SRC_CHANGE: begin rf_waddr = ROT_REG;   rf_wdata = {30'd0, rot_q + 2'd1}; end
        default:    begin rf_waddr = SCORE_REG; rf_wdata = 32'd0; end
      endcase
    end
  end

  always_comb begin
    lfsr_d         = {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? 16'hB400 : 16'h0000);
    stop_pend_d    = stop_pend_q;
    change_pend_d  = change_pend_q;
    restart_pend_d = restart_pend_q;
    clear_cnt_d    = clear_cnt_q;
    score_d        = score_q;
    rot_d          = rot_q;
    shape_d        = shape_q;
    ptr_d          = ptr_q;
    if (grant_valid) begin
      ptr_d = grant_src + 2'd1;
      case (grant_src)
        SRC_STOP:   begin shape_d = cand; rot_d = 2'd0; stop_pend_d = 1'b0; end
        SRC_CLEAR:  begin score_d = score_q + 32'd1; clear_cnt_d = clear_cnt_q - 4'd1; end
        SRC_CHANGE: begin rot_d = rot_q + 2'd1; change_pend_d = 1'b0; end
        default:    begin score_d = 32'd0; restart_pend_d = 1'b0; end
      endcase
    end
    if (cpu_win && !force_evt && cpu_waddr == SCORE_REG) score_d = cpu_wdata;
    // New edges land after the grant retires so a same-cycle edge re-arms its source.
    if (stop_edge)    stop_pend_d    = 1'b1;
    if (change_edge)  change_pend_d  = 1'b1;
    if (restart_edge) restart_pend_d = 1'b1;
    if (clear_edge && clear_cnt_d != 4'hF) clear_cnt_d = clear_cnt_d + 4'd1;
    if (!start_over) begin
      stop_pend_d    = 1'b0;
      change_pend_d  = 1'b0;
      restart_pend_d = 1'b0;
      clear_cnt_d    = 4'd0;
      score_d        = 32'd0;
      rot_d          = 2'd0;
    end
  end

  always_ff @(posedge clock or posedge ctrl_reset) begin
    if (ctrl_reset) begin
      stop_prev_q    <= 1'b0;
      clear_prev_q   <= 1'b0;
      change_prev_q  <= 1'b0;
      so_prev_q      <= 1'b0;
      stop_pend_q    <= 1'b0;
      change_pend_q  <= 1'b0;
      restart_pend_q <= 1'b0;
      clear_cnt_q    <= 4'd0;
      score_q        <= 32'd0;
      rot_q          <= 2'd0;
      shape_q        <= 4'd0;
      ptr_q          <= SRC_STOP;
      lfsr_q         <= 16'hACE1;
    end else begin
      stop_prev_q    <= ev_stop;
      clear_prev_q   <= ev_clear;
      change_prev_q  <= ev_change;
      so_prev_q      <= start_over;
      stop_pend_q    <= stop_pend_d;
      change_pend_q  <= change_pend_d;
      restart_pend_q <= restart_pend_d;
      clear_cnt_q    <= clear_cnt_d;
      score_q        <= score_d;
      rot_q          <= rot_d;
      shape_q        <= shape_d;
      ptr_q          <= ptr_d;
      lfsr_q         <= lfsr_d;
    end
  end

  assign shape   = shape_q;
  assign score   = score_q;
  assign pending = pend_vec;

endmodule

// File: tb/tb_rf_event_arbiter.sv
// Testbench for rf_event_arbiter: directed scenarios plus random traffic against a behavioural model.
module tb_rf_event_arbiter;

  localparam int MAX_WAIT = 8;

  logic        clock = 1'b0;
  logic        ctrl_reset;
  logic        cpu_we;
  logic [4:0]  cpu_waddr;
  logic [31:0] cpu_wdata;
  logic        ev_stop, ev_clear, ev_change, start_over;
  logic        rf_we;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;
  logic        cpu_stall;
  logic [3:0]  shape;
  logic [31:0] score;
  logic [3:0]  pending;

  int errors = 0;
  int checks = 0;

  always #5 clock = ~clock;

  rf_event_arbiter dut (
    .clock      (clock),
    .ctrl_reset (ctrl_reset),
    .cpu_we     (cpu_we),
    .cpu_waddr  (cpu_waddr),
    .cpu_wdata  (cpu_wdata),
    .ev_stop    (ev_stop),
    .ev_clear   (ev_clear),
    .ev_change  (ev_change),
    .start_over (start_over),
    .rf_we      (rf_we),
    .rf_waddr   (rf_waddr),
    .rf_wdata   (rf_wdata),
    .cpu_stall  (cpu_stall),
    .shape      (shape),
    .score      (score),
    .pending    (pending)
  );

  // Model state; sources are numbered 0 stop, 1 clear, 2 change, 3 restart.
  bit          m_pend[4];
  bit          m_prev[4];
  int          m_clr_cnt, m_ptr, m_rot, m_wait, m_lfsr;
  logic [31:0] m_score;
  logic [3:0]  m_shape;
  bit          m_cpu_win, m_frc, m_any;
  int          exp_grant;
  logic        exp_we, exp_stall;
  logic [4:0]  exp_waddr;
  logic [31:0] exp_wdata;
  logic [31:0] first_stop_data;

  function automatic bit m_is_pending(int s);
    if (s == 1) return m_clr_cnt > 0;
    return m_pend[s];
  endfunction

  function automatic logic [3:0] m_pending_vec();
    return {m_pend[3], m_pend[2], (m_clr_cnt > 0), m_pend[0]};
  endfunction

  function automatic logic [3:0] m_candidate();
    int v = m_lfsr % 16;
    return (v == 15) ? 4'd0 : 4'(v);
  endfunction

  function automatic void model_reset();
    for (int s = 0; s < 4; s++) begin m_pend[s] = 0; m_prev[s] = 0; end
    m_clr_cnt = 0; m_ptr = 0; m_rot = 0; m_wait = 0;
    m_lfsr = 'hACE1; m_score = 0; m_shape = 0;
  endfunction

  function automatic void model_eval();
    m_cpu_win = cpu_we && (cpu_waddr != 0);
    m_any = start_over && (m_pend[0] || m_clr_cnt > 0 || m_pend[2] || m_pend[3]);
    m_frc = 0;
`ifdef EVT_STARVE_GUARD_EN
    m_frc = m_cpu_win && m_any && (m_wait == MAX_WAIT);
`endif
    exp_grant = -1; exp_we = 0; exp_waddr = 0; exp_wdata = 0; exp_stall = m_frc;
    if (ctrl_reset) begin
      exp_stall = 0;
    end else if (m_cpu_win && !m_frc) begin
      exp_we = 1; exp_waddr = cpu_waddr; exp_wdata = cpu_wdata;
    end else if (m_any) begin
      for (int k = 0; k < 4; k++)
        if (exp_grant < 0 && m_is_pending((m_ptr + k) % 4)) exp_grant = (m_ptr + k) % 4;
      exp_we = 1;
      case (exp_grant)
        0: begin exp_waddr = 1;  exp_wdata = {28'd0, m_candidate()}; end
        1: begin exp_waddr = 13; exp_wdata = m_score + 1; end
        2: begin exp_waddr = 2;  exp_wdata = 32'((m_rot + 1) % 4); end
        default: begin exp_waddr = 13; exp_wdata = 0; end
      endcase
    end
  endfunction

  function automatic void model_commit();
    bit e[4];
    model_eval();
    e[0] = ev_stop && !m_prev[0];
    e[1] = ev_clear && !m_prev[1];
    e[2] = ev_change && !m_prev[2];
    e[3] = start_over && !m_prev[3];
    case (exp_grant)
      0: begin m_shape = m_candidate(); m_rot = 0; m_pend[0] = 0; end
      1: begin m_score = m_score + 1; m_clr_cnt--; end
      2: begin m_rot = (m_rot + 1) % 4; m_pend[2] = 0; end
      3: begin m_score = 0; m_pend[3] = 0; end
      default: ;
    endcase
    if (exp_grant >= 0) m_ptr = (exp_grant + 1) % 4;
    if (m_cpu_win && !m_frc && cpu_waddr == 13) m_score = cpu_wdata;
    if (e[0]) m_pend[0] = 1;
    if (e[2]) m_pend[2] = 1;
    if (e[3]) m_pend[3] = 1;
    if (e[1]) m_clr_cnt = (m_clr_cnt + 1 > 15) ? 15 : m_clr_cnt + 1;
    if (!start_over) begin
      m_pend[0] = 0; m_pend[2] = 0; m_pend[3] = 0; m_clr_cnt = 0; m_score = 0; m_rot = 0;
    end
    if (exp_grant >= 0 || !m_any) m_wait = 0;
    else if (m_cpu_win) m_wait++;
    m_prev[0] = ev_stop; m_prev[1] = ev_clear; m_prev[2] = ev_change; m_prev[3] = start_over;
    m_lfsr = (m_lfsr % 2 == 1) ? ((m_lfsr / 2) ^ 'hB400) : (m_lfsr / 2);
  endfunction

  task automatic drive(input logic we, input logic [4:0] a, input logic [31:0] d,
                       input logic s, input logic c, input logic ch, input logic so);
    cpu_we = we; cpu_waddr = a; cpu_wdata = d;
    ev_stop = s; ev_clear = c; ev_change = ch; start_over = so;
  endtask

  task automatic settle();
    @(negedge clock);
    model_eval();
  endtask

  task automatic advance();
    @(posedge clock);
    model_commit();
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      drive(0, 0, 0, 0, 0, 0, 1);
      settle();
      advance();
    end
  endtask

  task automatic test_reset();
    ctrl_reset = 1'b1;
    drive(1, 5'd5, 32'hDEAD_BEEF, 0, 0, 0, 1);
    #1;
    model_reset();
    settle();
    checks++; if (rf_we !== 1'b0) begin errors++; $display("[TB] FAIL reset_rf_we got %b want 0", rf_we); end
    checks++; if (rf_waddr !== 5'd0 || rf_wdata !== 32'd0) begin errors++; $display("[TB] FAIL reset_rf_addr_data got %h/%h want 0/0", rf_waddr, rf_wdata); end
    checks++; if (pending !== 4'd0 || cpu_stall !== 1'b0) begin errors++; $display("[TB] FAIL reset_pending_stall got %b/%b want 0/0", pending, cpu_stall); end
    checks++; if (score !== 32'd0 || shape !== 4'd0) begin errors++; $display("[TB] FAIL reset_score_shape got %h/%h want 0/0", score, shape); end
    @(posedge clock);
    #1;
    ctrl_reset = 1'b0;
  endtask

  task automatic test_single_stop();
    drive(0, 0, 0, 0, 0, 0, 1);
    settle();
    checks++; if (pending !== 4'd0) begin errors++; $display("[TB] FAIL post_reset_pending got %b want 0", pending); end
    advance();
    idle(3);
    drive(0, 0, 0, 1, 0, 0, 1);
    settle();
    checks++; if (rf_we !== 1'b0) begin errors++; $display("[TB] FAIL stop_before_edge rf_we got %b want 0", rf_we); end
    advance();
    drive(0, 0, 0, 0, 0, 0, 1);
    settle();
    first_stop_data = exp_wdata;
    checks++; if (rf_we !== 1'b1 || rf_waddr !== 5'd1 || rf_wdata !== exp_wdata) begin
      errors++; $display("[TB] FAIL stop_write got we=%b a=%0d d=%h want we=1 a=1 d=%h", rf_we, rf_waddr, rf_wdata, exp_wdata);
    end
    advance();
    settle();
    checks++; if (shape !== first_stop_data[3:0]) begin errors++; $display("[TB] FAIL stop_shape got %h want %h", shape, first_stop_data[3:0]); end
    checks++; if (pending !== 4'd0) begin errors++; $display("[TB] FAIL stop_pending got %b want 0", pending); end
    advance();
  endtask

  task automatic test_clear_burst();
    logic [31:0] base;
    base = m_score;
    for (int i = 0; i < 6; i++) begin
      drive(1, 5'd5, 32'h1234, 0, (i % 2 == 0), 0, 1);
      settle();
      checks++; if (rf_waddr !== 5'd5) begin errors++; $display("[TB] FAIL clear_cpu_busy got a=%0d want 5", rf_waddr); end
      advance();
    end
    for (int i = 0; i < 3; i++) begin
      drive(0, 0, 0, 0, 0, 0, 1);
      settle();
      checks++; if (rf_we !== 1'b1 || rf_waddr !== 5'd13 || rf_wdata !== base + 32'(i + 1)) begin
        errors++; $display("[TB] FAIL clear_write%0d got we=%b a=%0d d=%h want 1/13/%h", i, rf_we, rf_waddr, rf_wdata, base + 32'(i + 1));
      end
      advance();
    end
    settle();
    checks++; if (score !== base + 32'd3 || pending !== 4'd0) begin
      errors++; $display("[TB] FAIL clear_score got %h/%b want %h/0", score, pending, base + 32'd3);
    end
    advance();
  endtask

  task automatic test_cpu_priority();
    int n_change = 0;
    for (int c = 0; c < 14; c++) begin
      drive(1, 5'd5, 32'h1234, 0, 0, (c == 0), 1);
      settle();
      checks++; if (rf_we !== exp_we || rf_waddr !== exp_waddr || rf_wdata !== exp_wdata || cpu_stall !== exp_stall) begin
        errors++; $display("[TB] FAIL cpu_prio_c%0d got %b/%0d/%h/%b want %b/%0d/%h/%b", c, rf_we, rf_waddr, rf_wdata, cpu_stall, exp_we, exp_waddr, exp_wdata, exp_stall);
      end
`ifndef EVT_STARVE_GUARD_EN
      checks++; if (rf_waddr !== 5'd5 || cpu_stall !== 1'b0) begin errors++; $display("[TB] FAIL cpu_wins_c%0d got a=%0d stall=%b want 5/0", c, rf_waddr, cpu_stall); end
`endif
      if (rf_we === 1'b1 && rf_waddr === 5'd2) n_change++;
      advance();
    end
    for (int c = 0; c < 2; c++) begin
      drive(0, 0, 0, 0, 0, 0, 1);
      settle();
      checks++; if (rf_we !== exp_we || rf_waddr !== exp_waddr || rf_wdata !== exp_wdata) begin
        errors++; $display("[TB] FAIL cpu_idle_c%0d got %b/%0d/%h want %b/%0d/%h", c, rf_we, rf_waddr, rf_wdata, exp_we, exp_waddr, exp_wdata);
      end
      if (rf_we === 1'b1 && rf_waddr === 5'd2) n_change++;
      advance();
    end
    checks++; if (n_change != 1) begin errors++; $display("[TB] FAIL change_write_count got %0d want 1", n_change); end
  endtask

  task automatic test_restart();
    drive(1, 5'd13, 32'd7, 0, 0, 0, 1);
    settle();
    advance();
    drive(0, 0, 0, 0, 0, 0, 1);
    settle();
    checks++; if (score !== 32'd7) begin errors++; $display("[TB] FAIL cpu_score_load got %h want 7", score); end
    advance();
    drive(0, 0, 0, 0, 1, 0, 0);
    settle();
    checks++; if (rf_we !== 1'b0) begin errors++; $display("[TB] FAIL restart_low_we got %b want 0", rf_we); end
    advance();
    drive(0, 0, 0, 0, 0, 0, 0);
    settle();
    checks++; if (pending !== 4'd0 || score !== 32'd0) begin errors++; $display("[TB] FAIL restart_low_state got %b/%h want 0/0", pending, score); end
    advance();
    drive(0, 0, 0, 0, 0, 0, 1);
    settle();
    checks++; if (pending !== 4'd0) begin errors++; $display("[TB] FAIL restart_clear_ignored got %b want 0", pending); end
    advance();
    settle();
    checks++; if (rf_we !== 1'b1 || rf_waddr !== 5'd13 || rf_wdata !== 32'd0 || pending !== 4'b1000) begin
      errors++; $display("[TB] FAIL restart_grant got %b/%0d/%h/%b want 1/13/0/1000", rf_we, rf_waddr, rf_wdata, pending);
    end
    advance();
    settle();
    checks++; if (score !== 32'd0 || pending !== 4'd0) begin errors++; $display("[TB] FAIL restart_done got %h/%b want 0/0", score, pending); end
    advance();
  endtask

  task automatic test_simultaneous();
    logic [4:0] order[3];
    order[0] = 5'd1; order[1] = 5'd13; order[2] = 5'd2;
    drive(0, 0, 0, 1, 1, 1, 1);
    settle();
    advance();
    for (int i = 0; i < 3; i++) begin
      drive(0, 0, 0, 0, 0, 0, 1);
      settle();
      checks++; if (rf_we !== 1'b1 || rf_waddr !== order[i] || rf_wdata !== exp_wdata) begin
        errors++; $display("[TB] FAIL simul_grant%0d got %b/%0d/%h want 1/%0d/%h", i, rf_we, rf_waddr, rf_wdata, order[i], exp_wdata);
      end
      if (i == 2) begin
        checks++; if (rf_wdata !== 32'd1) begin errors++; $display("[TB] FAIL simul_rot got %h want 1", rf_wdata); end
      end
      advance();
    end
  endtask

  task automatic test_reset_mid_grant();
    drive(0, 0, 0, 1, 0, 0, 1);
    settle();
    advance();
    drive(0, 0, 0, 0, 0, 0, 1);
    settle();
    checks++; if (rf_we !== 1'b1) begin errors++; $display("[TB] FAIL midgrant_active got %b want 1", rf_we); end
    #1 ctrl_reset = 1'b1;
    #1;
    model_reset();
    checks++; if (rf_we !== 1'b0 || rf_waddr !== 5'd0 || rf_wdata !== 32'd0 || pending !== 4'd0) begin
      errors++; $display("[TB] FAIL async_reset got %b/%0d/%h/%b want 0/0/0/0", rf_we, rf_waddr, rf_wdata, pending);
    end
    @(posedge clock);
    #1;
    ctrl_reset = 1'b0;
    test_single_stop();
  endtask

  task automatic test_random();
    logic [4:0] addrs[6];
    addrs[0] = 0; addrs[1] = 1; addrs[2] = 2; addrs[3] = 13; addrs[4] = 5; addrs[5] = 31;
    for (int n = 0; n < 400; n++) begin
      drive(1'($urandom % 2), addrs[$urandom_range(0, 5)], $urandom,
            1'($urandom % 3 == 0), 1'($urandom % 3 == 0), 1'($urandom % 3 == 0), 1'($urandom % 20 != 0));
      settle();
      checks++; if (rf_we !== exp_we || rf_waddr !== exp_waddr || rf_wdata !== exp_wdata) begin
        errors++; $display("[TB] FAIL rand%0d_write got %b/%0d/%h want %b/%0d/%h", n, rf_we, rf_waddr, rf_wdata, exp_we, exp_waddr, exp_wdata);
      end
      checks++; if (cpu_stall !== exp_stall) begin errors++; $display("[TB] FAIL rand%0d_stall got %b want %b", n, cpu_stall, exp_stall); end
      checks++; if (pending !== m_pending_vec()) begin errors++; $display("[TB] FAIL rand%0d_pending got %b want %b", n, pending, m_pending_vec()); end
      checks++; if (score !== m_score || shape !== m_shape) begin
        errors++; $display("[TB] FAIL rand%0d_state got %h/%h want %h/%h", n, score, shape, m_score, m_shape);
      end
      advance();
    end
  endtask

  initial begin
    test_reset();
    test_single_stop();
    test_clear_burst();
    test_cpu_priority();
    test_restart();
    test_simultaneous();
    test_reset_mid_grant();
    checks++; if (rf_wdata !== rf_wdata || first_stop_data === 32'hx) begin errors++; $display("[TB] FAIL lfsr_restart_data got %h", first_stop_data); end
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog timeout errors=%0d checks=%0d", errors, checks);
    $fatal(1, "[TB] watchdog");
  end

endmodule
